ps2_to_ascii: RTL and testbench

- Decodes the core's 11-bit PS/2 key-event bus into ASCII bytes. It is the inverse of the ASCII-to-keyevent text writer used for BASIC text download.
- Tracks Shift and Caps Lock, translates make codes to ASCII, and buffers the result in a small FIFO with a valid/ready output handshake.
- Sits beside the keyboard matrix block and feeds a future text-capture/BASIC-save path that streams bytes to the HPS.

---
 rtl/ps2_to_ascii.sv | 249 ++++++++++++++++++++++++
 tb/tb_ps2_to_ascii.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_to_ascii.sv
// ---------------------------------------------------------------------------
// ps2_to_ascii
//   Turns the core's 11-bit PS/2 key-event bus into a stream of ASCII bytes.
//   Shift (left/right) and Caps Lock state are tracked internally, make codes
//   are translated to ASCII, and the results are queued in a small circular
//   FIFO drained through a valid/ready handshake.
//
//   Pipeline: stage 1 latches a new event (detected by a toggle of
//   ps2_key[10]); stage 2 decodes it, updates modifier state and writes the
//   FIFO. One event per cycle is sustained.
//
// Ports
//   clk             system clock
//   reset           synchronous, active-high reset
//   ps2_key[10:0]   [10] event toggle, [9] make(1)/break(0), [8] E0 prefix,
//                   [7:0] set-2 scancode
//   ascii_byte      head-of-FIFO byte (0 while the FIFO is empty)
//   ascii_valid     FIFO non-empty
//   ascii_ready     consumer accepts the head byte this cycle
//   fifo_count      current FIFO occupancy
//   overflow        sticky: a decoded byte was dropped on a full FIFO
//   clear_overflow  clears overflow (a same-cycle set takes priority)
// ---------------------------------------------------------------------------
module ps2_to_ascii #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [7:0]  CR_CODE    = 8'h0D
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [10:0]                   ps2_key,
  output logic [7:0]                    ascii_byte,
  output logic                          ascii_valid,
  input  logic                          ascii_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          clear_overflow
);

  localparam int              AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(FIFO_DEPTH);

  // -------------------------------------------------------------------------
  // Make-code translation. Returns {hit, byte}; hit=0 means "no write".
  // upper selects the letter case (shift ^ caps); shift alone selects the
  // alternate symbol on digit and punctuation keys.
  // -------------------------------------------------------------------------
  function automatic logic [8:0] map_key(input logic [7:0] code,
                                         input logic       shift,
                                         input logic       upper);
    logic [8:0] r;
    logic [7:0] idx;   // 1..26 for letters A..Z, 0 when not a letter
    r   = '0;
    idx = 8'd0;
    case (code)
      8'h1C: idx = 8'd1;   8'h32: idx = 8'd2;   8'h21: idx = 8'd3;
      8'h23: idx = 8'd4;   8'h24: idx = 8'd5;   8'h2B: idx = 8'd6;
      8'h34: idx = 8'd7;   8'h33: idx = 8'd8;   8'h43: idx = 8'd9;
      8'h3B: idx = 8'd10;  8'h42: idx = 8'd11;  8'h4B: idx = 8'd12;
      8'h3A: idx = 8'd13;  8'h31: idx = 8'd14;  8'h44: idx = 8'd15;
      8'h4D: idx = 8'd16;  8'h15: idx = 8'd17;  8'h2D: idx = 8'd18;
      8'h1B: idx = 8'd19;  8'h2C: idx = 8'd20;  8'h3C: idx = 8'd21;
      8'h2A: idx = 8'd22;  8'h1D: idx = 8'd23;  8'h22: idx = 8'd24;
      8'h35: idx = 8'd25;  8'h1A: idx = 8'd26;
      // Digit row: caps has no effect, only shift.
      8'h45: r = {1'b1, shift ? 8'h29 : 8'h30};
      8'h16: r = {1'b1, shift ? 8'h21 : 8'h31};
      8'h1E: r = {1'b1, shift ? 8'h40 : 8'h32};
      8'h26: r = {1'b1, shift ? 8'h23 : 8'h33};
      8'h25: r = {1'b1, shift ? 8'h24 : 8'h34};
      8'h2E: r = {1'b1, shift ? 8'h25 : 8'h35};
      8'h36: r = {1'b1, shift ? 8'h5E : 8'h36};
      8'h3D: r = {1'b1, shift ? 8'h26 : 8'h37};
      8'h3E: r = {1'b1, shift ? 8'h2A : 8'h38};
      8'h46: r = {1'b1, shift ? 8'h28 : 8'h39};
      // Punctuation.
      8'h4E: r = {1'b1, shift ? 8'h5F : 8'h2D};
      8'h55: r = {1'b1, shift ? 8'h2B : 8'h3D};
      8'h4C: r = {1'b1, shift ? 8'h3A : 8'h3B};
      8'h52: r = {1'b1, shift ? 8'h22 : 8'h27};
      8'h41: r = {1'b1, shift ? 8'h3C : 8'h2C};
      8'h49: r = {1'b1, shift ? 8'h3E : 8'h2E};
      8'h4A: r = {1'b1, shift ? 8'h3F : 8'h2F};
      // Control / whitespace.
      8'h29: r = {1'b1, 8'h20};
      8'h5A: r = {1'b1, CR_CODE};
      8'h66: r = {1'b1, 8'h08};
      8'h76: r = {1'b1, 8'h1B};
      default: r = '0;
    endcase
    if (idx != 8'd0) begin
      r = {1'b1, (upper ? 8'h41 : 8'h61) + idx - 8'd1};
    end
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // Stage 1: event detect and latch
  // -------------------------------------------------------------------------
  logic       strobe_q;
  logic       ev_valid_q;
  logic [9:0] ev_data_q;
  logic       ev_detect;

  assign ev_detect = ps2_key[10] ^ strobe_q;

  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // Track the current toggle level so a stale toggle is not taken as an
      // event once reset is released.
      strobe_q   <= ps2_key[10];
      ev_valid_q <= 1'b0;
      ev_data_q  <= '0;
    end else begin
      strobe_q   <= ps2_key[10];
      ev_valid_q <= ev_detect;
      if (ev_detect) begin
        ev_data_q <= ps2_key[9:0];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2: modifier tracking and decode
  // -------------------------------------------------------------------------
  logic       ev_make;
  logic       ev_ext;
  logic [7:0] ev_code;
  logic       shift_l_q, shift_l_d;
  logic       shift_r_q, shift_r_d;
  logic       caps_q,    caps_d;
  logic       dec_valid;
  logic [7:0] dec_byte;
  logic [8:0] map_r;

  assign ev_make = ev_data_q[9];
  assign ev_ext  = ev_data_q[8];
  assign ev_code = ev_data_q[7:0];

  // NOTE: every always_comb output gets a default first, so no path through
  // the case/if tree can leave a signal unassigned and infer a latch.
  always_comb begin
    shift_l_d = shift_l_q;
    shift_r_d = shift_r_q;
    caps_d    = caps_q;
    dec_valid = 1'b0;
    dec_byte  = 8'h00;
    map_r     = map_key(ev_code, shift_l_q | shift_r_q,
                        (shift_l_q | shift_r_q) ^ caps_q);

    if (ev_valid_q) begin
      if (ev_ext) begin
        // Only keypad Enter is meaningful among extended keys; E0 12
        // (fake shift) and everything else fall through untouched.
        if (ev_make && (ev_code == 8'h5A)) begin
          dec_valid = 1'b1;
          dec_byte  = CR_CODE;
        end
      end else begin
        case (ev_code)
          8'h12:   shift_l_d = ev_make;
          8'h59:   shift_r_d = ev_make;
          8'h58:   if (ev_make) caps_d = ~caps_q;
          default: begin
            if (ev_make) begin
              dec_valid = map_r[8];
              dec_byte  = map_r[7:0];
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_l_q <= 1'b0;
      shift_r_q <= 1'b0;
      caps_q    <= 1'b0;
    end else begin
      shift_l_q <= shift_l_d;
      shift_r_q <= shift_r_d;
      caps_q    <= caps_d;
    end
  end

  // -------------------------------------------------------------------------
  // Output FIFO
  // -------------------------------------------------------------------------
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          full;
  logic          pop;
  logic          push;

  assign full = (count_q == FULL_CNT);
  // A byte written this cycle is not visible until count_q reflects it, so an
  // empty FIFO can never pop the incoming byte in the same cycle.
  assign pop  = (count_q != '0) && ascii_ready;
  // A full FIFO still accepts a write when the head is leaving this cycle.
  assign push = dec_valid && (!full || pop);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    overflow_d = overflow_q;
    if (dec_valid && full && !pop) begin
      overflow_d = 1'b1;           // set wins over a same-cycle clear
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: storage is deliberately left out of reset; occupancy is governed by
  // the pointers and count, and the output is gated while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= dec_byte;
    end
  end

  assign ascii_valid = (count_q != '0);
  assign ascii_byte  = ascii_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign fifo_count  = count_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_ps2_to_ascii.sv
// ---------------------------------------------------------------------------
// tb_ps2_to_ascii
//   Self-checking bench for ps2_to_ascii. A table-driven reference model turns
//   each key event into the expected ASCII byte (or nothing) and keeps the
//   expected FIFO contents in a queue; directed scenarios and randomized
//   bursts are compared against it.
// ---------------------------------------------------------------------------
module tb_ps2_to_ascii;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [7:0]  ascii_byte;
  logic        ascii_valid;
  logic        ascii_ready;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic        clear_overflow;

  always #5 clk = ~clk;

  ps2_to_ascii #(.FIFO_DEPTH(DEPTH), .CR_CODE(8'h0D)) dut (
    .clk            (clk),
    .reset          (reset),
    .ps2_key        (ps2_key),
    .ascii_byte     (ascii_byte),
    .ascii_valid    (ascii_valid),
    .ascii_ready    (ascii_ready),
    .fifo_count     (fifo_count),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  int total = 0;
  int bad   = 0;

  // ------------------------- reference model -------------------------------
  byte unsigned letter_codes [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,
    8'h33,8'h43,8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,
    8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
  byte unsigned digit_codes  [10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,
    8'h3D,8'h3E,8'h46};
  byte unsigned digit_shift  [10] = '{8'h29,8'h21,8'h40,8'h23,8'h24,8'h25,8'h5E,
    8'h26,8'h2A,8'h28};
  byte unsigned punct_codes  [7]  = '{8'h4E,8'h55,8'h4C,8'h52,8'h41,8'h49,8'h4A};
  byte unsigned punct_plain  [7]  = '{8'h2D,8'h3D,8'h3B,8'h27,8'h2C,8'h2E,8'h2F};
  byte unsigned punct_shift  [7]  = '{8'h5F,8'h2B,8'h3A,8'h22,8'h3C,8'h3E,8'h3F};
  byte unsigned ctrl_codes   [4]  = '{8'h29,8'h5A,8'h66,8'h76};
  byte unsigned ctrl_bytes   [4]  = '{8'h20,8'h0D,8'h08,8'h1B};

  byte unsigned exp_q [$];
  bit m_shl, m_shr, m_caps, m_ovf;

  function automatic void model_reset();
    exp_q.delete();
    m_shl = 0; m_shr = 0; m_caps = 0; m_ovf = 0;
  endfunction

  function automatic void model_push(byte unsigned b);
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else m_ovf = 1;
  endfunction

  function automatic void model_event(bit mk, bit ex, byte unsigned code);
    bit sh;
    if (ex) begin
      if (mk && code == 8'h5A) model_push(8'h0D);
      return;
    end
    if (code == 8'h12) begin m_shl = mk; return; end
    if (code == 8'h59) begin m_shr = mk; return; end
    if (code == 8'h58) begin if (mk) m_caps = !m_caps; return; end
    if (!mk) return;
    sh = m_shl | m_shr;
    for (int i = 0; i < 26; i++)
      if (letter_codes[i] == code) begin
        model_push(byte'(((sh ^ m_caps) ? 8'h41 : 8'h61) + i));
        return;
      end
    for (int i = 0; i < 10; i++)
      if (digit_codes[i] == code) begin
        model_push(sh ? digit_shift[i] : byte'(8'h30 + i));
        return;
      end
    for (int i = 0; i < 7; i++)
      if (punct_codes[i] == code) begin
        model_push(sh ? punct_shift[i] : punct_plain[i]);
        return;
      end
    for (int i = 0; i < 4; i++)
      if (ctrl_codes[i] == code) begin
        model_push(ctrl_bytes[i]);
        return;
      end
  endfunction

  // ------------------------- stimulus helpers ------------------------------
  task automatic tick(int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Toggle the event strobe with new fields; consumes exactly one cycle.
  task automatic drive_event(bit mk, bit ex, byte unsigned code);
    ps2_key = {~ps2_key[10], mk, ex, code};
    tick();
  endtask

  task automatic send(bit mk, bit ex, byte unsigned code);
    drive_event(mk, ex, code);
    model_event(mk, ex, code);
  endtask

  task automatic drain(string tag);
    int budget;
    bit rdy;
    budget = 300;
    while (exp_q.size() > 0 && budget > 0) begin
      budget--;
      rdy = 1'($urandom_range(0, 1));
      ascii_ready = rdy;
      if (rdy) begin
        total++;
        if (ascii_valid !== 1'b1 || ascii_byte !== exp_q[0]) begin
          bad++;
          $display("FAIL %s pop: valid=%0b byte=%02h required valid=1 byte=%02h",
                   tag, ascii_valid, ascii_byte, exp_q[0]);
        end
      end
      tick();
      if (rdy) void'(exp_q.pop_front());
    end
    ascii_ready = 1'b0;
    total++;
    if (budget == 0) begin
      bad++;
      $display("FAIL %s drain timeout: %0d bytes still expected", tag, exp_q.size());
      exp_q.delete();
    end
    total++;
    if (ascii_valid !== 1'b0 || fifo_count !== 4'd0) begin
      bad++;
      $display("FAIL %s empty after drain: valid=%0b count=%0d required 0/0",
               tag, ascii_valid, fifo_count);
    end
  endtask

  task automatic clear_caps();
    if (m_caps) send(1, 0, 8'h58);
  endtask

  // ------------------------- scenarios -------------------------------------
  task automatic test_reset();
    bit seen_valid;
    ps2_key = 11'h400;
    ascii_ready = 0;
    clear_overflow = 0;
    reset = 1;
    tick(2);
    reset = 0;
    model_reset();
    seen_valid = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ascii_valid) seen_valid = 1;
    end
    total++;
    if (seen_valid || fifo_count !== 4'd0 || ascii_byte !== 8'h00 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL reset idle: seen_valid=%0b count=%0d byte=%02h ovf=%0b required 0/0/00/0",
               seen_valid, fifo_count, ascii_byte, overflow);
    end
  endtask

  task automatic test_latency();
    send(1, 0, 8'h1C);
    total++;
    if (ascii_valid !== 1'b0) begin
      bad++;
      $display("FAIL latency early: valid=%0b required 0 one edge after toggle", ascii_valid);
    end
    tick();
    total++;
    if (ascii_valid !== 1'b1 || ascii_byte !== 8'h61 || fifo_count !== 4'd1) begin
      bad++;
      $display("FAIL latency edge+2: valid=%0b byte=%02h count=%0d required 1/61/1",
               ascii_valid, ascii_byte, fifo_count);
    end
    ascii_ready = 1;
    tick();
    ascii_ready = 0;
    void'(exp_q.pop_front());
    total++;
    if (fifo_count !== 4'd0 || ascii_valid !== 1'b0) begin
      bad++;
      $display("FAIL single pop: count=%0d valid=%0b required 0/0", fifo_count, ascii_valid);
    end
  endtask

  task automatic test_modifiers();
    byte unsigned want [4] = '{8'h41, 8'h61, 8'h31, 8'h41};
    send(1, 0, 8'h12);
    send(1, 0, 8'h1C);
    send(0, 0, 8'h12);
    send(1, 0, 8'h1C);
    send(1, 0, 8'h58);
    send(1, 0, 8'h16);
    send(1, 0, 8'h1C);
    tick(2);
    total++;
    if (fifo_count !== 4'd4) begin
      bad++;
      $display("FAIL modifiers count: got=%0d required=4", fifo_count);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (ascii_byte !== want[i]) begin
        bad++;
        $display("FAIL modifiers byte%0d: got=%02h required=%02h", i, ascii_byte, want[i]);
      end
      ascii_ready = 1;
      tick();
      ascii_ready = 0;
      void'(exp_q.pop_front());
    end
    clear_caps();
    tick(2);
  endtask

  task automatic test_extended();
    send(1, 1, 8'h5A);
    send(1, 1, 8'h75);
    send(0, 0, 8'h1C);
    send(1, 0, 8'h0E);
    send(1, 1, 8'h12);
    tick(3);
    total++;
    if (fifo_count !== 4'd1 || ascii_byte !== 8'h0D) begin
      bad++;
      $display("FAIL extended/ignored: count=%0d byte=%02h required 1/0D", fifo_count, ascii_byte);
    end
    drain("extended");
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 10; i++) send(1, 0, letter_codes[i]);
    tick(2);
    total++;
    if (fifo_count !== 4'd8 || overflow !== 1'b1 || overflow !== m_ovf) begin
      bad++;
      $display("FAIL overflow fill: count=%0d ovf=%0b required 8/1", fifo_count, overflow);
    end
    clear_overflow = 1;
    tick();
    clear_overflow = 0;
    m_ovf = 0;
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL clear_overflow: got=%0b required=0", overflow);
    end
    // Dropped write on the same edge as clear_overflow: set must win.
    send(1, 0, 8'h1C);
    clear_overflow = 1;
    tick();
    clear_overflow = 0;
    total++;
    if (overflow !== 1'b1 || fifo_count !== 4'd8) begin
      bad++;
      $display("FAIL set-vs-clear: ovf=%0b count=%0d required 1/8", overflow, fifo_count);
    end
    // Write landing on the same edge as a pop while full.
    drive_event(1, 0, 8'h32);
    ascii_ready = 1;
    total++;
    if (ascii_byte !== exp_q[0]) begin
      bad++;
      $display("FAIL full head: got=%02h required=%02h", ascii_byte, exp_q[0]);
    end
    tick();
    ascii_ready = 0;
    void'(exp_q.pop_front());
    exp_q.push_back(8'h62);
    total++;
    if (fifo_count !== 4'd8) begin
      bad++;
      $display("FAIL write+pop when full: count=%0d required=8", fifo_count);
    end
    clear_overflow = 1;
    tick();
    clear_overflow = 0;
    m_ovf = 0;
    drain("overflow");
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL overflow final: got=%0b required=0", overflow);
    end
  endtask

  task automatic test_reset_mid();
    clear_caps();
    send(1, 0, 8'h12);
    for (int i = 0; i < 5; i++) send(1, 0, letter_codes[$urandom_range(0, 25)]);
    tick(2);
    total++;
    if (fifo_count !== 4'd5) begin
      bad++;
      $display("FAIL pre-reset count: got=%0d required=5", fifo_count);
    end
    reset = 1;
    tick();
    reset = 0;
    model_reset();
    total++;
    if (fifo_count !== 4'd0 || ascii_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid-stream reset: count=%0d valid=%0b required 0/0", fifo_count, ascii_valid);
    end
    send(1, 0, 8'h1C);
    tick(2);
    total++;
    if (ascii_byte !== 8'h61 || fifo_count !== 4'd1) begin
      bad++;
      $display("FAIL shift cleared by reset: byte=%02h count=%0d required 61/1",
               ascii_byte, fifo_count);
    end
    drain("reset_mid");
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(1, 12);
      for (int e = 0; e < n; e++) begin
        byte unsigned code;
        bit mk, ex;
        case ($urandom_range(0, 9))
          0, 1, 2, 3: code = letter_codes[$urandom_range(0, 25)];
          4:          code = digit_codes[$urandom_range(0, 9)];
          5:          code = punct_codes[$urandom_range(0, 6)];
          6:          code = ctrl_codes[$urandom_range(0, 3)];
          7:          begin
                        case ($urandom_range(0, 2))
                          0:       code = 8'h12;
                          1:       code = 8'h59;
                          default: code = 8'h58;
                        endcase
                      end
          8:          code = 8'h0E;
          default:    code = 8'($urandom_range(0, 255));
        endcase
        mk = ($urandom_range(0, 3) != 0);
        ex = ($urandom_range(0, 9) == 0);
        send(mk, ex, code);
        if ($urandom_range(0, 3) == 0) tick();
      end
      tick(3);
      total++;
      if (fifo_count !== 4'(exp_q.size()) || overflow !== m_ovf) begin
        bad++;
        $display("FAIL random round%0d: count=%0d ovf=%0b required %0d/%0b",
                 r, fifo_count, overflow, exp_q.size(), m_ovf);
      end
      drain("random");
      clear_overflow = 1;
      tick();
      clear_overflow = 0;
      m_ovf = 0;
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_modifiers();
    test_extended();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
